// File: rtl/central_pu.sv
// rtl/central_pu.sv - accumulator CPU with unified memory; CENTRAL_PU_SHIFT_EN enables SHL/SHR

// Unified instruction/data memory: combinational read, synchronous write
module central_pu_mem #(
  parameter int WIDTH = 12,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] internal_mem [0:(2**AW)-1];

  assign o_rdata = internal_mem[i_raddr];

  // Single write port, used only by ST during EXEC
  always_ff @(posedge clk) begin
    if (i_we) internal_mem[i_waddr] <= i_wdata;
  end
endmodule

module central_pu #(
  parameter int INSTR_SIZE   = 12,
  parameter int DATA_SIZE    = 8,
  parameter int OPCODE_SIZE  = 4,
  parameter int ADDR_SIZE    = 5,
  parameter int PROGRAM_SIZE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic out_of_bounds
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  // Wide enough to hold pc plus a sign-extended 8-bit offset without overflow
  localparam int TW = ADDR_SIZE + DATA_SIZE + 1;
  localparam logic signed [TW-1:0] PROG_LIM = TW'(PROGRAM_SIZE);
  localparam logic signed [TW-1:0] ONE      = {{(TW-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0]    r_pc, w_pc_nxt;
  logic [DATA_SIZE-1:0]    r_acc, w_acc_nxt, w_acc_res;
  logic [INSTR_SIZE-1:0]   r_ir, w_ir_nxt;
  logic                    r_oob, w_oob_nxt;

  logic [OPCODE_SIZE-1:0]  w_opcode;
  logic [DATA_SIZE-1:0]    w_op;
  logic [ADDR_SIZE-1:0]    w_addr, w_raddr;
  logic [INSTR_SIZE-1:0]   w_rdata, w_wdata;
  logic [DATA_SIZE-1:0]    w_mem_val;
  logic                    w_we, w_st_op, w_halt_op, w_taken, w_out;
  logic signed [TW-1:0]    w_pc_ext, w_off_ext, w_seq, w_br, w_target;

  assign w_opcode  = r_ir[INSTR_SIZE-1 -: OPCODE_SIZE];
  assign w_op      = r_ir[DATA_SIZE-1:0];
  assign w_addr    = w_op[ADDR_SIZE-1:0];
  assign w_raddr   = (r_state == S_EXEC) ? w_addr : r_pc;
  assign w_mem_val = w_rdata[DATA_SIZE-1:0];
  assign w_wdata   = {{(INSTR_SIZE-DATA_SIZE){r_acc[DATA_SIZE-1]}}, r_acc};

  assign w_pc_ext  = {{(TW-ADDR_SIZE){1'b0}}, r_pc};
  assign w_off_ext = {{(TW-DATA_SIZE){w_op[DATA_SIZE-1]}}, w_op};
  assign w_seq     = w_pc_ext + ONE;
  assign w_br      = w_pc_ext + w_off_ext;
  assign w_target  = w_taken ? w_br : w_seq;
  assign w_out     = w_target[TW-1] || (w_target >= PROG_LIM);

  central_pu_mem #(.WIDTH(INSTR_SIZE), .AW(ADDR_SIZE)) mem0 (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Instruction decode: accumulator result, store request, branch decision
  always_comb begin
    w_acc_res = r_acc;
    w_st_op   = 1'b0;
    w_halt_op = 1'b0;
    w_taken   = 1'b0;
    case (w_opcode)
      4'h1: w_acc_res = w_mem_val;
      4'h2: w_acc_res = r_acc + w_mem_val;
      4'h3: w_acc_res = r_acc - w_mem_val;
      4'h4: w_acc_res = r_acc & w_mem_val;
      4'h5: w_acc_res = r_acc | w_mem_val;
      4'h6: w_acc_res = r_acc ^ w_mem_val;
      4'h7: w_acc_res = ~r_acc;
`ifdef CENTRAL_PU_SHIFT_EN
      4'h8: w_acc_res = {r_acc[DATA_SIZE-2:0], 1'b0};
      4'h9: w_acc_res = {r_acc[DATA_SIZE-1], r_acc[DATA_SIZE-1:1]};
`else
      4'h8, 4'h9: w_acc_res = r_acc;
`endif
      4'hA: w_acc_res = w_op;
      4'hB: w_acc_res = r_acc + w_op;
      4'hC: w_st_op   = 1'b1;
      4'hD: w_taken   = (r_acc == '0);
      4'hE: w_taken   = r_acc[DATA_SIZE-1];
      4'hF: w_halt_op = 1'b1;
      default: ;
    endcase
  end

  // FSM next state; an out-of-range target freezes pc, acc and memory
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_nxt    = r_ir;
    w_oob_nxt   = r_oob;
    w_we        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_nxt    = w_rdata;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_halt_op) begin
          w_state_nxt = S_HALT;
        end else if (w_out) begin
          w_oob_nxt   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt    = w_target[ADDR_SIZE-1:0];
          w_acc_nxt   = w_acc_res;
          w_we        = w_st_op;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // State and architectural registers; memory is deliberately not reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_acc   <= '0;
      r_ir    <= '0;
      r_oob   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_acc   <= w_acc_nxt;
      r_ir    <= w_ir_nxt;
      r_oob   <= w_oob_nxt;
    end
  end

  assign out_of_bounds = r_oob;
endmodule

// File: tb/tb_central_pu.sv
// tb/tb_central_pu.sv - self-checking bench for central_pu with an ISA-level reference model
module tb_central_pu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_of_bounds;

  always #5 clk = ~clk;

  central_pu dut (.clk(clk), .rst_n(rst_n), .out_of_bounds(out_of_bounds));

`ifdef CENTRAL_PU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] prog [32];
  int m_mem [32];
  int m_pc, m_acc;
  bit m_oob, m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 12'h000;
  endtask

  // Preload memory under reset, mirror it into the model, release reset at a falling edge
  task automatic load_and_start();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      dut.mem0.internal_mem[i] <= prog[i];
      m_mem[i] = int'(prog[i]);
    end
    m_pc = 0; m_acc = 0; m_oob = 1'b0; m_halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One instruction of the ISA, evaluated with plain integer arithmetic
  task automatic model_step();
    int instr, opc, op, a, imm, npc, nacc;
    bit st, hlt;
    if (m_halt) return;
    instr = m_mem[m_pc];
    opc = (instr >> 8) & 15;
    op  = instr & 255;
    a   = op % 32;
    imm = (op >= 128) ? op - 256 : op;
    npc = m_pc + 1; nacc = m_acc; st = 1'b0; hlt = 1'b0;
    case (opc)
      1:  nacc = m_mem[a] & 255;
      2:  nacc = (m_acc + (m_mem[a] & 255)) & 255;
      3:  nacc = (m_acc - (m_mem[a] & 255)) & 255;
      4:  nacc = m_acc & m_mem[a] & 255;
      5:  nacc = (m_acc | m_mem[a]) & 255;
      6:  nacc = (m_acc ^ m_mem[a]) & 255;
      7:  nacc = 255 - m_acc;
      8:  if (SHIFT_EN) nacc = (m_acc * 2) & 255;
      9:  if (SHIFT_EN) nacc = (m_acc / 2) + ((m_acc >= 128) ? 128 : 0);
      10: nacc = op;
      11: nacc = (m_acc + imm) & 255;
      12: st = 1'b1;
      13: if (m_acc == 0) npc = m_pc + imm;
      14: if (m_acc >= 128) npc = m_pc + imm;
      15: hlt = 1'b1;
      default: ;
    endcase
    if (hlt) begin m_halt = 1'b1; return; end
    if (npc < 0 || npc >= 16) begin m_oob = 1'b1; m_halt = 1'b1; return; end
    if (st) m_mem[a] = (m_acc >= 128) ? m_acc + 3840 : m_acc;
    m_acc = nacc;
    m_pc  = npc;
  endtask

  // Advance DUT by n instructions (2 clocks each) and the model by n steps
  task automatic run_instr(input int n);
    repeat (2 * n) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < n; i++) model_step();
  endtask

  task automatic compare_model(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 32; i++)
      if (int'(dut.mem0.internal_mem[i]) != m_mem[i]) mism++;
    check({tag, "_pc"},  32'(dut.r_pc),  32'(m_pc));
    check({tag, "_acc"}, 32'(dut.r_acc), 32'(m_acc));
    check({tag, "_oob"}, 32'(out_of_bounds), 32'(m_oob));
    check({tag, "_mem"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int q16 [$];
    int last16, cyc;
    logic [11:0] snap [32];
    logic [11:0] w;

    // Reset state
    #12;
    check("rst_oob", 32'(out_of_bounds), 32'd0);
    check("rst_pc",  32'(dut.r_pc), 32'd0);
    check("rst_acc", 32'(dut.r_acc), 32'd0);

    // Countdown program
    clear_prog();
    prog[0] = 12'hA05; prog[1] = 12'hC11; prog[2] = 12'hE0E; prog[3] = 12'h111;
    prog[4] = 12'hC10; prog[5] = 12'hBFF; prog[6] = 12'hC11; prog[7] = 12'h700;
    prog[8] = 12'hB01; prog[9] = 12'hEFA; prog[10] = 12'hDF9;
    prog[16] = 12'h0AA;
    load_and_start();
    last16 = 'h0AA;
    cyc = 0;
    while (cyc < 120 && !out_of_bounds) begin
      @(negedge clk);
      cyc++;
      if (int'(dut.mem0.internal_mem[16]) != last16) begin
        last16 = int'(dut.mem0.internal_mem[16]);
        q16.push_back(last16);
      end
    end
    check("cd_oob_within_120", 32'(out_of_bounds), 32'd1);
    check("cd_writes", 32'(q16.size()), 32'd6);
    for (int i = 0; i < q16.size() && i < 6; i++)
      check("cd_mem16_seq", 32'(q16[i]), 32'(5 - i));
    check("cd_mem16", 32'(dut.mem0.internal_mem[16]), 32'h000);
    check("cd_mem17", 32'(dut.mem0.internal_mem[17]), 32'hFFF);
    for (int i = 0; i < 80; i++) model_step();
    compare_model("cd_model");

    // Wrap to 0x80 then BN taken
    clear_prog();
    prog[0] = 12'hA7F; prog[1] = 12'hB01; prog[2] = 12'hE02; prog[3] = 12'hA11; prog[4] = 12'hF00;
    load_and_start();
    run_instr(3);
    check("wrap_acc", 32'(dut.r_acc), 32'h80);
    check("bn_pc", 32'(dut.r_pc), 32'd4);
    run_instr(3);
    compare_model("wrap_model");

    // BN forward past the program end
    clear_prog();
    prog[0] = 12'hA80; prog[1] = 12'hE0F;
    load_and_start();
    run_instr(2);
    check("bn_oob", 32'(out_of_bounds), 32'd1);
    check("bn_oob_pc", 32'(dut.r_pc), 32'd1);
    run_instr(2);
    check("bn_oob_pc_frozen", 32'(dut.r_pc), 32'd1);
    check("bn_oob_acc", 32'(dut.r_acc), 32'h80);

    // BZ to a negative target
    clear_prog();
    prog[0] = 12'hD80;
    load_and_start();
    run_instr(1);
    check("bz_neg_oob", 32'(out_of_bounds), 32'd1);
    check("bz_neg_pc", 32'(dut.r_pc), 32'd0);

    // Asynchronous reset while flagged: clears immediately, memory kept
    for (int i = 0; i < 32; i++) snap[i] = dut.mem0.internal_mem[i];
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_oob", 32'(out_of_bounds), 32'd0);
    check("async_rst_pc", 32'(dut.r_pc), 32'd0);
    begin
      int mism;
      mism = 0;
      for (int i = 0; i < 32; i++) if (dut.mem0.internal_mem[i] !== snap[i]) mism++;
      check("async_rst_mem", 32'(mism), 32'd0);
    end

    // Reset during the EXEC of a store aborts the write
    clear_prog();
    prog[0] = 12'hA33; prog[1] = 12'hC14; prog[20] = 12'h123;
    load_and_start();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_st_mem20", 32'(dut.mem0.internal_mem[20]), 32'h123);
    check("abort_st_acc", 32'(dut.r_acc), 32'd0);

    // SHL behaviour depends on the build macro
    clear_prog();
    prog[0] = 12'hA41; prog[1] = 12'h800; prog[2] = 12'hF00;
    load_and_start();
    run_instr(2);
    check("shl_acc", 32'(dut.r_acc), SHIFT_EN ? 32'h82 : 32'h41);
    check("shl_pc", 32'(dut.r_pc), 32'd2);

    // Random programs against the model
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 32; i++) begin
        w = 12'($urandom);
        if (i < 16) w[11:8] = 4'($urandom_range(0, 14));
        prog[i] = w;
      end
      if (t % 5 == 0) prog[15] = 12'hF00;
      load_and_start();
      run_instr(24);
      compare_model($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
